// File: rtl/nibble_field_pkg.sv
// nibble_field_pkg: shared constants and types for the nibble field arbiter
package nibble_field_pkg;
  localparam int FIELD_LSB = 4;
  localparam int FIELD_MSB = 83;
  localparam int FIELD_W = FIELD_MSB - FIELD_LSB + 1;
  localparam int NIB_W = 4;
  typedef enum logic {DIR_PLUS, DIR_MINUS} dir_e;
  typedef struct packed {
    logic we;
    dir_e dir;
    logic [6:0] bitn;
    logic [NIB_W-1:0] wdata;
  } nib_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant with a blocking input, owns the priority pointer
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic                     block,
  output logic [NREQ-1:0]          gnt,
  output logic [$clog2(NREQ)-1:0]  gnt_idx
);
  localparam int IW = $clog2(NREQ);
  logic [IW-1:0] rr;
  always_comb begin
    logic [IW-1:0] c;
    gnt = '0;
    gnt_idx = '0;
    c = '0;
    // Scan farthest offset first so the requester closest to rr wins last.
    for (int o = NREQ - 1; o >= 0; o--) begin
      c = IW'((int'(rr) + o) % NREQ);
      if (!block && req[c]) begin
        gnt_idx = c;
        gnt = '0;
        gnt[c] = 1'b1;
      end
    end
  end
  always_ff @(posedge clk)
    if (reset) rr <= '0;
    else if (|gnt) rr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
endmodule

// File: rtl/nibble_field_arb.sv
// nibble_field_arb: arbitrated nibble read/write into field[FMSB:FLSB] with range clipping
module nibble_field_arb
  import nibble_field_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int FLSB = FIELD_LSB,
  parameter int FMSB = FIELD_MSB
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [FMSB-FLSB:0]         load_data,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            we,
  input  logic [NREQ-1:0]            dir,
  input  logic [NREQ*7-1:0]          bitn,
  input  logic [NREQ*NIB_W-1:0]      wdata,
  output logic [NREQ-1:0]            gnt,
  output logic                       rvalid,
  output logic [$clog2(NREQ)-1:0]    rid,
  output logic [NIB_W-1:0]           rdata,
  output logic                       oob,
  output logic [FMSB-FLSB:0]         field
);
  localparam int IW = $clog2(NREQ);
  localparam int FW = FMSB - FLSB + 1;
  localparam int PW = $clog2(FW);
  logic [IW-1:0] gi;
  logic [NIB_W-1:0] inr, rd;
  logic [FW-1:0] fnext;
  nib_req_t g;
  int idx;
  logic [PW-1:0] p;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk(clk), .reset(reset), .req(req), .block(load | reset), .gnt(gnt), .gnt_idx(gi)
  );
  always_comb g = '{we: we[gi], dir: dir_e'(dir[gi]), bitn: bitn[gi*7 +: 7], wdata: wdata[gi*NIB_W +: NIB_W]};
  // Signed index math without wrap: bits landing outside the field are masked off.
  always_comb begin
    inr = '0;
    rd = '0;
    fnext = field;
    idx = 0;
    p = '0;
    for (int k = 0; k < NIB_W; k++) begin
      idx = int'(g.bitn) + k - (g.dir == DIR_MINUS ? 3 : 0);
      p = PW'(idx - FLSB);
      if (idx >= FLSB && idx <= FMSB) begin
        inr[k] = 1'b1;
        rd[k] = field[p];
        if (g.we) fnext[p] = g.wdata[k];
      end
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      field <= '0;
      rvalid <= 1'b0;
      rid <= '0;
      rdata <= '0;
      oob <= 1'b0;
    end else begin
      rvalid <= |gnt && !g.we;
      if (load) field <= load_data;
      else if (|gnt) begin
        field <= fnext;
        oob <= ~&inr;
        if (!g.we) begin
          rid <= gi;
          rdata <= rd;
        end
      end
    end
endmodule

// File: tb/tb_nibble_field_arb.sv
// tb_nibble_field_arb: directed literal checks plus randomized traffic against a bit-level model
module tb_nibble_field_arb;
  localparam int N = 4;
  logic clk = 0, reset = 1, load = 0;
  logic [79:0] load_data = '0;
  logic [N-1:0] req = '0, we = '0, dir = '0;
  logic [N*7-1:0] bitn = '0;
  logic [N*4-1:0] wdata = '0;
  logic [N-1:0] gnt;
  logic rvalid, oob;
  logic [1:0] rid;
  logic [3:0] rdata;
  logic [79:0] field;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  logic [79:0] mf = '0;
  int mrr = 0;
  logic mrv = 0, moob = 0;
  logic [1:0] mrid = '0;
  logic [3:0] mrd = '0;
  int bnd [12] = '{0, 1, 2, 3, 4, 5, 80, 81, 82, 83, 84, 127};

  nibble_field_arb dut (
    .clk(clk), .reset(reset), .load(load), .load_data(load_data), .req(req), .we(we),
    .dir(dir), .bitn(bitn), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rid(rid),
    .rdata(rdata), .oob(oob), .field(field)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [79:0] act, logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] e = '0;
    if (!reset && !load)
      for (int o = 0; o < N; o++)
        if (req[(mrr + o) % N]) begin
          e[(mrr + o) % N] = 1'b1;
          break;
        end
    return e;
  endfunction

  // Model: a plain bit array with the nibble covering lo..lo+3, clipped to 4..83.
  initial forever begin
    logic [N-1:0] eg;
    @(negedge clk);
    eg = exp_gnt();
    if (chk_en) begin
      chk("m_gnt", 80'(gnt), 80'(eg));
      chk("m_field", field, mf);
      chk("m_rvalid", 80'(rvalid), 80'(mrv));
      chk("m_rid", 80'(rid), 80'(mrid));
      chk("m_rdata", 80'(rdata), 80'(mrd));
      chk("m_oob", 80'(oob), 80'(moob));
    end
    if (reset) begin
      mf = '0; mrr = 0; mrv = 0; mrid = '0; mrd = '0; moob = 0;
    end else if (load) begin
      mf = load_data; mrv = 0;
    end else if (eg != 0) begin
      int i, lo, a;
      logic [3:0] nib;
      logic out;
      i = 0;
      for (int j = 0; j < N; j++) if (eg[j]) i = j;
      lo = int'(bitn[i*7 +: 7]) - (dir[i] ? 3 : 0);
      nib = '0;
      out = 0;
      for (int k = 0; k < 4; k++) begin
        a = lo + k;
        if (a >= 4 && a <= 83) begin
          if (we[i]) mf[a-4] = wdata[i*4+k];
          else nib[k] = mf[a-4];
        end else out = 1;
      end
      mrv = !we[i];
      moob = out;
      if (!we[i]) begin
        mrid = 2'(i);
        mrd = nib;
      end
      mrr = (i + 1) % N;
    end else mrv = 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, bit w, bit d, int b, logic [3:0] wd);
    req[i] = 1'b1; we[i] = w; dir[i] = d; bitn[i*7 +: 7] = 7'(b); wdata[i*4 +: 4] = wd;
  endtask

  initial begin
    tick(); tick();
    reset = 0;
    chk_en = 1;
    tick();
    #1 chk("rst_field", field, 80'h0);
    chk("rst_rvalid", 80'(rvalid), 80'h0);
    chk("rst_gnt", 80'(gnt), 80'h0);
    load = 1; load_data = '0; tick(); load = 0;
    set_req(0, 1, 0, 7, 4'hA);
    #1 chk("w7_gnt", 80'(gnt), 80'h1);
    tick();
    chk("w7_field", field, 80'h50);
    set_req(0, 0, 1, 10, 4'h0);
    tick(); req = '0;
    chk("r10_rdata", 80'(rdata), 80'hA);
    chk("r10_rid", 80'(rid), 80'h0);
    chk("r10_rvalid", 80'(rvalid), 80'h1);
    chk("r10_oob", 80'(oob), 80'h0);
    load = 1; load_data = '0; tick(); load = 0;
    set_req(0, 1, 0, 82, 4'hF); tick(); req = '0;
    chk("w82_field", field, 80'hC0000000000000000000);
    chk("w82_oob", 80'(oob), 80'h1);
    set_req(0, 0, 0, 82, 4'h0); tick(); req = '0;
    chk("r82_rdata", 80'(rdata), 80'h3);
    set_req(0, 0, 1, 5, 4'h0); tick(); req = '0;
    chk("r5m_rdata", 80'(rdata), 80'h0);
    chk("r5m_oob", 80'(oob), 80'h1);
    set_req(0, 1, 0, 127, 4'hF); tick(); req = '0;
    chk("w127_field", field, 80'hC0000000000000000000);
    chk("w127_oob", 80'(oob), 80'h1);
    set_req(0, 0, 1, 2, 4'h0); tick(); req = '0;
    chk("r2m_rdata", 80'(rdata), 80'h0);
    chk("r2m_oob", 80'(oob), 80'h1);
    reset = 1; req = '1; we = '0; dir = '0; bitn = {4{7'd16}};
    tick(); reset = 0;
    #1 chk("rr_c0", 80'(gnt), 80'h1);
    tick(); chk("rr_c1", 80'(gnt), 80'h2);
    tick(); load = 1; load_data = 80'h1234;
    #1 chk("rr_load", 80'(gnt), 80'h0);
    tick(); load = 0;
    #1 chk("rr_c3", 80'(gnt), 80'h4);
    tick(); chk("rr_c4", 80'(gnt), 80'h8);
    tick(); chk("rr_c5", 80'(gnt), 80'h1);
    req = '0;
    reset = 1; tick(); reset = 0;
    set_req(1, 1, 1, 20, 4'h5);
    #1 chk("b2b_gnt1", 80'(gnt), 80'h2);
    tick(); req = '0;
    set_req(2, 0, 0, 17, 4'h0);
    #1 chk("b2b_gnt2", 80'(gnt), 80'h4);
    tick(); req = '0;
    chk("b2b_rdata", 80'(rdata), 80'h5);
    chk("b2b_rid", 80'(rid), 80'h2);
    set_req(0, 1, 0, 30, 4'hF); reset = 1;
    #1 chk("rstw_gnt", 80'(gnt), 80'h0);
    tick(); reset = 0; req = '0;
    chk("rstw_field", field, 80'h0);
    repeat (3000) begin
      reset = ($urandom % 100) == 0;
      load = ($urandom % 20) == 0;
      load_data = {16'($urandom()), $urandom(), $urandom()};
      req = 4'($urandom()); we = 4'($urandom()); dir = 4'($urandom());
      wdata = 16'($urandom());
      for (int i = 0; i < N; i++)
        bitn[i*7 +: 7] = ($urandom % 2) ? 7'(bnd[$urandom % 12]) : 7'($urandom_range(0, 127));
      tick();
    end
    req = '0; load = 0; reset = 0;
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
